sdram_arbiter: RTL and testbench
================================

Name: sdram_arbiter

Overview:
- Shares the single-command host interface of the SDRAM controller between two requesters.
  - Port 0: video/HDMI frame fetch.
  - Port 1: general host read/write.
- Serialises one 16-bit access at a time.
- Drives the controller's enables and absorbs its registered busy lag and refresh stalls.
- Routes read data back to the granted port.

Parameters:
- HADDR_WIDTH, 24, host word address width (bank+row+col), matches the controller.
- DATA_WIDTH, 16, data word width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- p0_req  in  1  port 0 request; held with p0_we/p0_addr/p0_wdata stable until p0_ack
- p0_we  in  1  1=write, 0=read
- p0_addr  in  HADDR_WIDTH  word address
- p0_wdata  in  DATA_WIDTH  write data
- p0_ack  out  1  one-cycle pulse: command accepted by controller
- p0_rdata  out  DATA_WIDTH  read data
- p0_rvalid  out  1  one-cycle pulse: p0_rdata valid
- p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_rdata, p1_rvalid: same as port 0
- ctl_wr_addr  out  HADDR_WIDTH  to controller wr_addr
- ctl_wr_data  out  DATA_WIDTH  to controller wr_data
- ctl_wr_enable  out  1  to controller wr_enable
- ctl_rd_addr  out  HADDR_WIDTH  to controller rd_addr
- ctl_rd_enable  out  1  to controller rd_enable
- ctl_rd_data  in  DATA_WIDTH  from controller rd_data
- ctl_rd_ready  in  1  from controller rd_ready
- ctl_busy  in  1  from controller busy (registered; lags controller state by one cycle)

Behaviour:
- Reset:
  - State IDLE; round-robin pointer = port 0.
  - All enables, acks and rvalids = 0; rdata and ctl address/data outputs = 0.
  - Reset mid-transaction abandons it; no ack or rvalid is produced afterwards.
- States:
  - IDLE: pick a winner among asserted reqs. Latch its index, we, addr and wdata into grant registers. Go to ISSUE. No req: stay.
  - ISSUE:
    - Assert ctl_rd_enable or ctl_wr_enable (per latched we) every cycle; ctl_* addr/data come from grant registers.
    - Hold until ctl_busy=1 is sampled. Holding is mandatory: the controller ignores enables while refreshing and busy lags by one cycle.
    - On ctl_busy=1: deassert enable that same cycle; pulse ack on the granted port; go to WAIT.
  - WAIT:
    - Read: on ctl_rd_ready=1, copy ctl_rd_data to the granted port's rdata, pulse its rvalid, go to DRAIN.
    - Write: on ctl_busy=0, go to IDLE.
  - DRAIN (read only): wait for ctl_busy=0, then IDLE. rd_ready arrives while busy is still 1.
- Arbitration:
  - Round-robin. On simultaneous reqs, the port not served last wins. Pointer updates at ack.
  - A single requester is granted back-to-back with no penalty beyond the state sequence.
- Non-granted port: ack/rvalid stay 0; its inputs are ignored until granted.
- Requester may deassert req after ack. Re-asserting req for the next access is allowed in the ack cycle +1.
- rdata holds the last value until the next rvalid for that port.
- Never assert ctl_rd_enable and ctl_wr_enable together. Never assert either outside ISSUE.
- Minimum turnaround per access: IDLE→ISSUE→(≥2 cycles)→WAIT→…→IDLE.

Optional Feature:
- SDRAM_ARB_FIXED_PRIO_EN
  - Defined: port 0 (video) always wins when both request. The round-robin pointer is removed.
  - Undefined: round-robin as above.

Decomposition:
- Package sdram_arb_pkg:
  - State encoding constants: IDLE, ISSUE, WAIT, DRAIN.
  - Port index constants: PORT_VIDEO=0, PORT_HOST=1.
- Sub-module sdram_arb_rr: 2-way round-robin grant.
  - Inputs: req[1:0], advance, clk, rst.
  - Output: one-hot grant.
  - Replaced by a fixed-priority encoder under the macro.

Test Plan:
- p1 write addr 0x00_1234 data 0xBEEF, controller model asserts busy 2 cycles after enable → ctl_wr_enable high exactly until busy sampled; p1_ack 1 pulse; IDLE after busy falls.
- p0 read addr 0x12_3400, model returns 0xA5A5 on rd_ready → p0_ack then p0_rvalid with p0_rdata=0xA5A5; p1_rvalid stays 0.
- Both req continuously (reads) → grants alternate 0,1,0,1 over 4 accesses. With SDRAM_ARB_FIXED_PRIO_EN: all 4 to port 0.
- Model in refresh (busy low, ignores enable 10 cycles) on p0 request → enable held 10+ cycles; single ack; no duplicate command.
- rst asserted in WAIT of a read → next cycle all enables/ack/rvalid 0; late ctl_rd_ready ignored; state IDLE.
- p0 write 0x0001 to addr 5 then p0 read addr 5 back-to-back → read issued only after write's busy falls; rdata 0x0001.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sdram_arb_pkg                                                |
// | Description : Shared types and constants for the two-port SDRAM arbiter:   |
// |               FSM state encoding, port index constants and a one-hot       |
// |               helper.                                                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } arb_state_t;

    localparam logic PORT_VIDEO = 1'b0;
    localparam logic PORT_HOST  = 1'b1;

    function automatic logic [1:0] port_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sdram_arb_rr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sdram_arb_rr                                                 |
// | Description : Two-way grant generator. Round-robin by default: the port    |
// |               not served last wins a tie; the pointer moves on 'advance'.  |
// |               With SDRAM_ARB_FIXED_PRIO_EN defined it becomes a fixed      |
// |               priority encoder (port 0 always wins) with no pointer.       |
// | Ports       : clk, rst   - clock, synchronous active-high reset            |
// |               req[1:0]   - request vector                                  |
// |               advance    - served-port pointer update strobe               |
// |               grant[1:0] - one-hot grant (zero when no request)            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sdram_arb_rr
    import sdram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

`ifdef SDRAM_ARB_FIXED_PRIO_EN
    // Clock, reset and advance have no function in fixed-priority mode.
    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, clk, rst, advance};

    always_comb begin
        grant = 2'b00;
        if (req[PORT_VIDEO]) begin
            grant[PORT_VIDEO] = 1'b1;
        end else if (req[PORT_HOST]) begin
            grant[PORT_HOST] = 1'b1;
        end
    end
`else
    // Index of the port that currently holds priority.
    logic r_ptr;

    always_comb begin
        grant = 2'b00;
        if (req[r_ptr]) begin
            grant[r_ptr] = 1'b1;
        end else if (req[~r_ptr]) begin
            grant[~r_ptr] = 1'b1;
        end
    end

    // After serving port 0 priority passes to port 1 and vice versa.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= PORT_VIDEO;
        end else if (advance && (|grant)) begin
            r_ptr <= grant[PORT_VIDEO];
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/sdram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sdram_arbiter                                                |
// | Description : Shares the single-command SDRAM controller host interface    |
// |               between port 0 (video fetch) and port 1 (host access).       |
// |               One 16-bit access in flight at a time; enables are held in   |
// |               ISSUE until the controller's (lagging) busy is seen, which   |
// |               also rides out refresh stalls. Read data is routed back to   |
// |               the granted port.                                            |
// | Ports       : clk, rst            - clock, sync active-high reset          |
// |               p0_* / p1_*         - requester ports (req/we/addr/wdata in, |
// |                                     ack/rdata/rvalid out)                  |
// |               ctl_*               - SDRAM controller host interface        |
// | Config      : SDRAM_ARB_FIXED_PRIO_EN - port 0 wins all ties (no RR)       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int HADDR_WIDTH = 24,
    parameter int DATA_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   p0_req,
    input  logic                   p0_we,
    input  logic [HADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0]  p0_wdata,
    output logic                   p0_ack,
    output logic [DATA_WIDTH-1:0]  p0_rdata,
    output logic                   p0_rvalid,
    input  logic                   p1_req,
    input  logic                   p1_we,
    input  logic [HADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0]  p1_wdata,
    output logic                   p1_ack,
    output logic [DATA_WIDTH-1:0]  p1_rdata,
    output logic                   p1_rvalid,
    output logic [HADDR_WIDTH-1:0] ctl_wr_addr,
    output logic [DATA_WIDTH-1:0]  ctl_wr_data,
    output logic                   ctl_wr_enable,
    output logic [HADDR_WIDTH-1:0] ctl_rd_addr,
    output logic                   ctl_rd_enable,
    input  logic [DATA_WIDTH-1:0]  ctl_rd_data,
    input  logic                   ctl_rd_ready,
    input  logic                   ctl_busy
);

    arb_state_t             r_state;
    arb_state_t             w_state_nxt;

    logic                   r_gnt_idx;
    logic                   r_gnt_we;
    logic [HADDR_WIDTH-1:0] r_gnt_addr;
    logic [DATA_WIDTH-1:0]  r_gnt_wdata;

    logic                   r_p0_rvalid;
    logic                   r_p1_rvalid;
    logic [DATA_WIDTH-1:0]  r_p0_rdata;
    logic [DATA_WIDTH-1:0]  r_p1_rdata;

    logic [1:0]             w_rr_req;
    logic [1:0]             w_grant;
    logic                   w_take;
    logic                   w_accept;
    logic                   w_rd_done;
    logic                   w_sel;

    // Outside IDLE the grant generator only sees the port already granted,
    // so its grant still names that port when the ack advances the pointer.
    assign w_rr_req = (r_state == IDLE) ? {p1_req, p0_req} : port_onehot(r_gnt_idx);
    assign w_sel    = w_grant[PORT_HOST];

    sdram_arb_rr u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     (w_rr_req),
        .advance (w_accept),
        .grant   (w_grant)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_take        = 1'b0;
        w_accept      = 1'b0;
        w_rd_done     = 1'b0;
        ctl_rd_enable = 1'b0;
        ctl_wr_enable = 1'b0;
        case (r_state)
            IDLE: begin
                if (|w_grant) begin
                    w_take      = 1'b1;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                // Busy is the only proof the controller took the command; it
                // lags one cycle and stays low through refresh, so keep asking.
                if (ctl_busy) begin
                    w_accept    = 1'b1;
                    w_state_nxt = WAIT;
                end else if (r_gnt_we) begin
                    ctl_wr_enable = 1'b1;
                end else begin
                    ctl_rd_enable = 1'b1;
                end
            end
            WAIT: begin
                if (r_gnt_we) begin
                    if (!ctl_busy) begin
                        w_state_nxt = IDLE;
                    end
                end else if (ctl_rd_ready) begin
                    w_rd_done   = 1'b1;
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (!ctl_busy) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        // A cycle with reset asserted never emits a command or an ack.
        if (rst) begin
            w_accept      = 1'b0;
            ctl_rd_enable = 1'b0;
            ctl_wr_enable = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_gnt_idx   <= PORT_VIDEO;
            r_gnt_we    <= 1'b0;
            r_gnt_addr  <= '0;
            r_gnt_wdata <= '0;
            r_p0_rvalid <= 1'b0;
            r_p1_rvalid <= 1'b0;
            r_p0_rdata  <= '0;
            r_p1_rdata  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_p0_rvalid <= w_rd_done && (r_gnt_idx == PORT_VIDEO);
            r_p1_rvalid <= w_rd_done && (r_gnt_idx == PORT_HOST);
            if (w_take) begin
                r_gnt_idx   <= w_sel;
                r_gnt_we    <= w_sel ? p1_we    : p0_we;
                r_gnt_addr  <= w_sel ? p1_addr  : p0_addr;
                r_gnt_wdata <= w_sel ? p1_wdata : p0_wdata;
            end
            if (w_rd_done && (r_gnt_idx == PORT_VIDEO)) begin
                r_p0_rdata <= ctl_rd_data;
            end
            if (w_rd_done && (r_gnt_idx == PORT_HOST)) begin
                r_p1_rdata <= ctl_rd_data;
            end
        end
    end

    assign p0_ack      = w_accept && (r_gnt_idx == PORT_VIDEO);
    assign p1_ack      = w_accept && (r_gnt_idx == PORT_HOST);
    assign p0_rvalid   = r_p0_rvalid;
    assign p1_rvalid   = r_p1_rvalid;
    assign p0_rdata    = r_p0_rdata;
    assign p1_rdata    = r_p1_rdata;
    assign ctl_wr_addr = r_gnt_addr;
    assign ctl_wr_data = r_gnt_wdata;
    assign ctl_rd_addr = r_gnt_addr;

endmodule
`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_sdram_arbiter                                             |
// | Description : Scoreboard bench for sdram_arbiter with a behavioural SDRAM  |
// |               controller model (registered busy, refresh stall window).    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_sdram_arbiter;

    localparam int AW = 24;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
    logic [AW-1:0] p0_addr = '0, p1_addr = '0;
    logic [DW-1:0] p0_wdata = '0, p1_wdata = '0;
    logic          p0_ack, p0_rvalid, p1_ack, p1_rvalid;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic [AW-1:0] ctl_wr_addr, ctl_rd_addr;
    logic [DW-1:0] ctl_wr_data;
    logic          ctl_wr_enable, ctl_rd_enable;
    logic [DW-1:0] ctl_rd_data = '0;
    logic          ctl_rd_ready = 1'b0;
    logic          ctl_busy = 1'b0;

    always #5 clk = ~clk;

    sdram_arbiter #(.HADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_rdata(p0_rdata), .p0_rvalid(p0_rvalid),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_rdata(p1_rdata), .p1_rvalid(p1_rvalid),
        .ctl_wr_addr(ctl_wr_addr), .ctl_wr_data(ctl_wr_data), .ctl_wr_enable(ctl_wr_enable),
        .ctl_rd_addr(ctl_rd_addr), .ctl_rd_enable(ctl_rd_enable),
        .ctl_rd_data(ctl_rd_data), .ctl_rd_ready(ctl_rd_ready), .ctl_busy(ctl_busy)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard queues: ack port, {port,rdata}, {we,addr,wdata}.
    int            exp_ack[$];
    logic [16:0]   exp_rd[$];
    logic [40:0]   exp_cmd[$];

    task automatic expect_access(input int port, input logic we, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] wd, input logic [DW-1:0] rd);
        exp_ack.push_back(port);
        exp_cmd.push_back({we, addr, wd});
        if (!we) exp_rd.push_back({port[0], rd});
    endtask

    // ---------------- controller model ----------------
    int            cyc = 0;
    int            refresh_until = 0;
    int            n_cmds = 0;
    logic          m_active = 1'b0;
    int            m_cnt = 0;
    logic          m_we = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] mem[int];
    logic [40:0]   m_e;

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        if (a == 24'h123400) return 16'hA5A5;
        if (a >= 24'h10 && a <= 24'h13) return 16'h1000 + DW'(a - 24'h10);
        if (a >= 24'h20 && a <= 24'h23) return 16'h2000 + DW'(a - 24'h20);
        return 16'h0;
    endfunction

    always @(posedge clk) begin
        cyc          <= cyc + 1;
        ctl_busy     <= m_active;
        ctl_rd_ready <= 1'b0;
        if (m_active) begin
            if (!m_we && m_cnt == 2) begin
                ctl_rd_ready <= 1'b1;
                ctl_rd_data  <= mem.exists(int'(m_addr)) ? mem[int'(m_addr)] : init_val(m_addr);
            end
            if (m_cnt == 0) m_active <= 1'b0;
            else            m_cnt    <= m_cnt - 1;
        end else if (cyc >= refresh_until && (ctl_rd_enable || ctl_wr_enable)) begin
            m_active <= 1'b1;
            m_cnt    <= 4;
            n_cmds   <= n_cmds + 1;
            if (ctl_wr_enable) begin
                m_we   <= 1'b1;
                m_addr <= ctl_wr_addr;
                mem[int'(ctl_wr_addr)] = ctl_wr_data;
            end else begin
                m_we   <= 1'b0;
                m_addr <= ctl_rd_addr;
            end
            if (exp_cmd.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_cmd: got wr=%0b addr=0x%0h, required no command",
                         ctl_wr_enable, ctl_wr_enable ? ctl_wr_addr : ctl_rd_addr);
            end else begin
                m_e = exp_cmd.pop_front();
                check("cmd_we", 64'(ctl_wr_enable), 64'(m_e[40]));
                check("cmd_addr", 64'(ctl_wr_enable ? ctl_wr_addr : ctl_rd_addr), 64'(m_e[39:16]));
                if (m_e[40]) check("cmd_wdata", 64'(ctl_wr_data), 64'(m_e[15:0]));
            end
        end
    end

    // ---------------- monitor ----------------
    logic          both_en_seen = 1'b0;
    int            en_run = 0, last_run = 0;
    logic          prev_en = 1'b0, prev_busy = 1'b0;
    int            busy_fall_cyc = -1, prev_rise_cyc = -1;
    logic          rise_ok = 1'b0;
    int            ea;
    logic [16:0]   er;

    initial forever begin
        @(negedge clk);
        if (ctl_rd_enable && ctl_wr_enable) both_en_seen = 1'b1;
        if (ctl_rd_enable || ctl_wr_enable) begin
            if (!prev_en) begin
                rise_ok       = (busy_fall_cyc > prev_rise_cyc);
                prev_rise_cyc = cyc;
            end
            en_run++;
        end else if (en_run != 0) begin
            last_run = en_run;
            en_run   = 0;
        end
        prev_en = ctl_rd_enable || ctl_wr_enable;
        if (prev_busy && !ctl_busy) busy_fall_cyc = cyc;
        prev_busy = ctl_busy;

        if (p0_ack || p1_ack) begin
            if (exp_ack.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_ack: got p0_ack=%0b p1_ack=%0b, required none", p0_ack, p1_ack);
            end else begin
                ea = exp_ack.pop_front();
                check("ack_port", 64'({p1_ack, p0_ack}), (ea == 0) ? 64'h1 : 64'h2);
            end
        end
        if (p0_rvalid || p1_rvalid) begin
            if (exp_rd.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_rvalid: got p0_rvalid=%0b p1_rvalid=%0b, required none",
                         p0_rvalid, p1_rvalid);
            end else begin
                er = exp_rd.pop_front();
                check("rvalid_port", 64'({p1_rvalid, p0_rvalid}), er[16] ? 64'h2 : 64'h1);
                check("rdata", 64'(er[16] ? p1_rdata : p0_rdata), 64'(er[15:0]));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input int port, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd, input bit hold_req);
        bit got;
        if (port == 0) begin
            p0_we = we; p0_addr = addr; p0_wdata = wd; p0_req = 1'b1;
        end else begin
            p1_we = we; p1_addr = addr; p1_wdata = wd; p1_req = 1'b1;
        end
        got = 1'b0;
        for (int n = 0; n < 300 && !got; n++) begin
            @(negedge clk);
            got = (port == 0) ? p0_ack : p1_ack;
        end
        if (!got) begin
            checks++; failures++;
            $display("FAIL ack_timeout: port %0d got no ack in 300 cycles, required an ack", port);
        end
        @(negedge clk);
        if (!hold_req) begin
            if (port == 0) p0_req = 1'b0;
            else           p1_req = 1'b0;
        end
    endtask

    task automatic port_seq(input int port, input logic [AW-1:0] base);
        for (int i = 0; i < 4; i++) drive(port, 1'b0, base + AW'(i), '0, i < 3);
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 400 && !done; n++) begin
            @(negedge clk);
            done = (exp_ack.size() == 0) && (exp_rd.size() == 0) && !m_active && !ctl_busy;
        end
        if (!done) begin
            checks++; failures++;
            $display("FAIL drain_timeout: got acks_left=%0d reads_left=%0d, required 0 and 0",
                     exp_ack.size(), exp_rd.size());
        end
        repeat (2) @(negedge clk);
    endtask

    // ---------------- main sequence ----------------
    int cmds_before;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_p0_ack", 64'(p0_ack), 0);
        check("rst_p1_ack", 64'(p1_ack), 0);
        check("rst_p0_rvalid", 64'(p0_rvalid), 0);
        check("rst_p1_rvalid", 64'(p1_rvalid), 0);
        check("rst_rd_en", 64'(ctl_rd_enable), 0);
        check("rst_wr_en", 64'(ctl_wr_enable), 0);
        check("rst_p0_rdata", 64'(p0_rdata), 0);
        check("rst_p1_rdata", 64'(p1_rdata), 0);
        check("rst_wr_addr", 64'(ctl_wr_addr), 0);
        check("rst_wr_data", 64'(ctl_wr_data), 0);
        check("rst_rd_addr", 64'(ctl_rd_addr), 0);
        rst = 1'b0;
        @(negedge clk);

        // Port 1 write: enable held exactly the two cycles until busy shows.
        expect_access(1, 1'b1, 24'h001234, 16'hBEEF, '0);
        drive(1, 1'b1, 24'h001234, 16'hBEEF, 1'b0);
        wait_idle();
        check("t1_wr_en_cycles", 64'(last_run), 2);

        // Port 0 read.
        expect_access(0, 1'b0, 24'h123400, '0, 16'hA5A5);
        drive(0, 1'b0, 24'h123400, '0, 1'b0);
        wait_idle();

        // Both ports read continuously after a fresh reset.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
`ifdef SDRAM_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 4; i++) expect_access(0, 1'b0, 24'h10 + AW'(i), '0, 16'h1000 + DW'(i));
        for (int i = 0; i < 4; i++) expect_access(1, 1'b0, 24'h20 + AW'(i), '0, 16'h2000 + DW'(i));
`else
        for (int i = 0; i < 4; i++) begin
            expect_access(0, 1'b0, 24'h10 + AW'(i), '0, 16'h1000 + DW'(i));
            expect_access(1, 1'b0, 24'h20 + AW'(i), '0, 16'h2000 + DW'(i));
        end
`endif
        fork
            port_seq(0, 24'h10);
            port_seq(1, 24'h20);
        join
        wait_idle();

        // Refresh window: enable must be held through 10 ignored cycles.
        cmds_before   = n_cmds;
        refresh_until = cyc + 10;
        expect_access(0, 1'b1, 24'h000040, 16'h4444, '0);
        drive(0, 1'b1, 24'h000040, 16'h4444, 1'b0);
        wait_idle();
        check("t4_en_held_ge10", 64'(last_run >= 10), 1);
        check("t4_single_cmd", 64'(n_cmds - cmds_before), 1);

        // Reset while waiting for read data: everything quiet, late data dropped.
        exp_ack.push_back(1);
        exp_cmd.push_back({1'b0, 24'h000020, 16'h0});
        drive(1, 1'b0, 24'h000020, '0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("t5_rd_en", 64'(ctl_rd_enable), 0);
        check("t5_wr_en", 64'(ctl_wr_enable), 0);
        check("t5_p0_ack", 64'(p0_ack), 0);
        check("t5_p1_ack", 64'(p1_ack), 0);
        check("t5_p1_rvalid", 64'(p1_rvalid), 0);
        check("t5_p1_rdata", 64'(p1_rdata), 0);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        wait_idle();

        // Back-to-back write then read of the same word on port 0.
        expect_access(0, 1'b1, 24'h000005, 16'h0001, '0);
        expect_access(0, 1'b0, 24'h000005, '0, 16'h0001);
        drive(0, 1'b1, 24'h000005, 16'h0001, 1'b1);
        drive(0, 1'b0, 24'h000005, '0, 1'b0);
        wait_idle();
        check("t6_read_after_busy_fall", 64'(rise_ok), 1);

        check("no_dual_enable", 64'(both_en_seen), 0);
        check("total_cmds", 64'(n_cmds), 14);
        check("cmds_left", 64'(exp_cmd.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: got no completion by 300us, required completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
